// File: rtl/pow_sched_pkg.sv
// Shared types and helpers for the round-robin power-pipeline scheduler.
// Holds the default geometry, the in-flight tag layout and the round-robin pick function.
package pow_sched_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_N_STAGES = 4;
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_ID_W     = 2;
  localparam int LAT          = DEF_N_STAGES + 1;

  // Upper bounds so one tag/pick layout serves every legal requester count.
  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr+1, ptr+2, ... cyclically over n_req entries; first active request wins.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0]  req,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int                  n_req);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    idx  = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n_req) begin
        idx = int'(ptr) + k;
        if (idx >= n_req) idx = idx - n_req;
        if (!pick.found && req[idx[MAX_ID_W-1:0]]) begin
          pick.found = 1'b1;
          pick.idx   = idx[MAX_ID_W-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pow_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant plus granted index, pointer moves to the last winner.
module pow_sched_rr_arb
  import pow_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  logic [ID_W-1:0]    ptr;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;
  logic               unused_idx_bits;

  assign req_ext         = MAX_REQ'(req);
  assign pick            = rr_next(req_ext, MAX_ID_W'(ptr), N_REQ);
  assign unused_idx_bits = ^pick.idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    if (en && pick.found) begin
      gnt_id                  = pick.idx[ID_W-1:0];
      gnt[pick.idx[ID_W-1:0]] = 1'b1;
    end
  end

  // Pointer starts at the last requester so requester 0 has first priority out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(N_REQ - 1);
    end else if (en && pick.found) begin
      ptr <= pick.idx[ID_W-1:0];
    end
  end

endmodule

// File: rtl/pow_pipe_rr_sched.sv
// Round-robin scheduler in front of an external n^(N_STAGES+1) pipeline, with tag tracking and a response register.
// Optional POW_SCHED_ERR_EN adds pipe_res_vld/err to flag pipeline-valid vs tag-valid disagreement.
module pow_pipe_rr_sched
  import pow_sched_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic               hold,
  output logic               rsp_vld,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_data,
  input  logic               rsp_rdy,
  output logic               idle,
  output logic               pipe_clk_en,
  output logic               pipe_n_vld,
  output logic [W-1:0]       pipe_n,
  input  logic [W-1:0]       pipe_res
`ifdef POW_SCHED_ERR_EN
  ,
  input  logic               pipe_res_vld,
  output logic               err
`endif
);

  localparam int PIPE_LAT = N_STAGES + 1;

  logic            adv;
  logic            issue_en;
  logic            any_gnt;
  logic            any_tag;
  logic [ID_W-1:0] gnt_id;
  tag_t            tags [PIPE_LAT];
  tag_t            tag_out;
  logic            unused_tag_bits;

  // A stalled output register freezes the whole pipeline, so nothing may issue either.
  assign adv         = !rsp_vld || rsp_rdy;
  assign pipe_clk_en = adv;
  assign issue_en    = adv && !hold && !rst;

  pow_sched_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vld),
    .en     (issue_en),
    .gnt    (req_rdy),
    .gnt_id (gnt_id)
  );

  assign any_gnt    = |req_rdy;
  assign pipe_n_vld = any_gnt;
  assign pipe_n     = any_gnt ? req_data[int'(gnt_id)*W +: W] : '0;

  // Tags shift in lockstep with the enabled pipeline; the last entry lines up with pipe_res.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tags[i] <= '0;
    end else if (adv) begin
      tags[0].vld <= any_gnt;
      tags[0].id  <= MAX_ID_W'(gnt_id);
      for (int i = 1; i < PIPE_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign tag_out         = tags[PIPE_LAT-1];
  assign unused_tag_bits = ^tag_out.id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (adv) begin
      rsp_vld <= tag_out.vld;
      if (tag_out.vld) begin
        rsp_id   <= tag_out.id[ID_W-1:0];
        rsp_data <= pipe_res;
      end
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) any_tag = any_tag | tags[i].vld;
  end

  assign idle = !rsp_vld && !any_tag;

`ifdef POW_SCHED_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (adv && (pipe_res_vld != tag_out.vld)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
